// File: rtl/polar_frame_scheduler.sv
// Round-robin two-source frame scheduler feeding the polar framing stage.
// Ports: clk/reset, enb, req/len/bit/rd per source, busy_in, out_data/valid, grants, frame_last, err_len.
module polar_frame_scheduler #(
  parameter int LEN_W      = 10,
  parameter int MAX_LEN    = 1023,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             req0,
  input  logic [LEN_W-1:0] len0,
  input  logic             bit0,
  output logic             rd0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len1,
  input  logic             bit1,
  output logic             rd1,
  input  logic             busy_in,
  output logic             out_data,
  output logic             out_valid,
  output logic             grant0,
  output logic             grant1,
  output logic             frame_last,
  output logic             err_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [LEN_W:0] MAX_W    = (LEN_W+1)'(MAX_LEN);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t           state;
  logic             sel;
  logic             rr_ptr;
  logic             rr_vld;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       gap_cnt;

  logic             win;
  logic [LEN_W-1:0] wlen;
  logic             len_ok;
  logic             start;
  logic             send;
  logic             last;

  // rr_vld stays low until the first grant so that a tie right
  // after reset goes to source 0 rather than to ~rr_ptr.
  always_comb begin
    win = 1'b0;
    if (req0 && req1)
      win = rr_vld ? ~rr_ptr : 1'b0;
    else
      win = req1;
  end

  assign wlen   = win ? len1 : len0;
  assign len_ok = (wlen != '0) && ({1'b0, wlen} <= MAX_W);
  assign start  = (state == IDLE) && !busy_in && (req0 || req1);

  assign send = (state == SEND);
  assign last = (cnt == len_q - LEN_W'(1));

  assign out_valid  = send;
  assign grant0     = send && !sel;
  assign grant1     = send && sel;
  assign out_data   = send && (sel ? bit1 : bit0);
  assign rd0        = send && !sel && enb;
  assign rd1        = send && sel && enb;
  assign frame_last = send && last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 1'b0;
      rr_ptr  <= 1'b0;
      rr_vld  <= 1'b0;
      cnt     <= '0;
      len_q   <= '0;
      gap_cnt <= '0;
      err_len <= 1'b0;
    end else begin
      // err_len is a strict single-cycle pulse
      err_len <= 1'b0;
      if (enb) begin
        case (state)
          IDLE: begin
            if (start) begin
              rr_ptr <= win;
              rr_vld <= 1'b1;
              sel    <= win;
              len_q  <= wlen;
              cnt    <= '0;
              if (len_ok)
                state <= SEND;
              else
                err_len <= 1'b1;
            end
          end
          SEND: begin
            cnt <= cnt + LEN_W'(1);
            if (last) begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST)
              state <= IDLE;
            else
              gap_cnt <= gap_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_polar_frame_scheduler.sv
// Directed bench for polar_frame_scheduler: vector table plus
// hand-written arbitration, busy, reset and stall sequences.
module tb_polar_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enb;
  logic       req0, req1;
  logic [9:0] len0, len1;
  logic       bit0, bit1;
  logic       rd0, rd1;
  logic       busy_in;
  logic       out_data, out_valid;
  logic       grant0, grant1;
  logic       frame_last, err_len;

  logic [63:0] pay0, pay1;
  int          idx0, idx1;
  int          npass = 0;
  int          ntot  = 0;

  assign bit0 = (idx0 < 64) ? pay0[idx0] : 1'b1;
  assign bit1 = (idx1 < 64) ? pay1[idx1] : 1'b1;

  always #5 clk = ~clk;

  polar_frame_scheduler #(
    .LEN_W(10), .MAX_LEN(1023), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .enb(enb),
    .req0(req0), .len0(len0), .bit0(bit0), .rd0(rd0),
    .req1(req1), .len1(len1), .bit1(bit1), .rd1(rd1),
    .busy_in(busy_in),
    .out_data(out_data), .out_valid(out_valid),
    .grant0(grant0), .grant1(grant1),
    .frame_last(frame_last), .err_len(err_len)
  );

  typedef struct {
    logic       r0;
    logic [9:0] l0;
    logic       r1;
    logic [9:0] l1;
    logic       bz;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[13];

  function automatic logic [7:0] outs();
    return {out_valid, out_data, grant0, grant1,
            rd0, rd1, frame_last, err_len};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle: remember pops, let the edge pass, advance the sources.
  task automatic tick();
    logic p0, p1;
    p0 = rd0;
    p1 = rd1;
    @(posedge clk);
    if (p0) idx0++;
    if (p1) idx1++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    req0 = 0; req1 = 0; busy_in = 0; enb = 1;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    idx0 = 0; idx1 = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int runs, cur, low;
    logic prev;
    int rl[4];
    int gl[4];
    logic rg[4];
    int nb, st, lastpos, rds;
    logic [5:0] dbits;
    logic done;

    pay0 = {{60{1'b1}}, 4'b1101};
    pay1 = {{62{1'b1}}, 2'b10};
    len0 = 0; len1 = 0;
    idle_in();
    idx0 = 0; idx1 = 0;
    reset = 1;
    @(negedge clk);
    #1 chk("reset_outs", {24'd0, outs()}, 32'd0);
    @(negedge clk);
    reset = 0;

    // r0..r5 illegal length then source 1; r6..r12 4-bit frame
    vt[0]  = '{1, 0, 1, 2, 0, 8'b0000_0000};
    vt[1]  = '{0, 0, 1, 2, 0, 8'b0000_0001};
    vt[2]  = '{0, 0, 0, 2, 0, 8'b1001_0100};
    vt[3]  = '{0, 0, 0, 2, 0, 8'b1101_0110};
    vt[4]  = '{0, 0, 0, 2, 0, 8'b0000_0000};
    vt[5]  = '{0, 0, 0, 2, 0, 8'b0000_0000};
    vt[6]  = '{1, 4, 0, 0, 0, 8'b0000_0000};
    vt[7]  = '{0, 9, 0, 0, 0, 8'b1110_1000};
    vt[8]  = '{0, 9, 0, 0, 1, 8'b1010_1000};
    vt[9]  = '{0, 9, 0, 0, 1, 8'b1110_1000};
    vt[10] = '{0, 9, 0, 0, 0, 8'b1110_1010};
    vt[11] = '{0, 9, 0, 0, 0, 8'b0000_0000};
    vt[12] = '{0, 9, 0, 0, 0, 8'b0000_0000};
    for (int i = 0; i < 13; i++) begin
      req0 = vt[i].r0; len0 = vt[i].l0;
      req1 = vt[i].r1; len1 = vt[i].l1;
      busy_in = vt[i].bz;
      #1 chk($sformatf("vec%0d", i), {24'd0, outs()},
             {24'd0, vt[i].exp});
      tick();
    end

    // Round robin with both requests held
    do_reset();
    req0 = 1; req1 = 1; len0 = 3; len1 = 5;
    runs = 0; cur = 0; low = 0; prev = 0;
    for (int c = 0; c < 200 && runs < 4; c++) begin
      #1;
      if (out_valid) begin
        if (!prev) begin
          rg[runs] = grant1;
          gl[runs] = low;
        end
        cur++;
      end else if (prev) begin
        rl[runs] = cur;
        runs++;
        cur = 0;
        low = 1;
      end else begin
        low++;
      end
      prev = out_valid;
      tick();
    end
    idle_in();
    chk("rr_runs", runs, 4);
    for (int k = 0; k < 4 && k < runs; k++) begin
      chk($sformatf("rr_grant%0d", k), {31'd0, rg[k]}, k % 2);
      chk($sformatf("rr_len%0d", k), rl[k], (k % 2) ? 5 : 3);
      if (k > 0) chk($sformatf("rr_gap%0d", k), gl[k], 2);
    end
    tick();

    // busy_in holds off the frame start
    req1 = 1; len1 = 2; busy_in = 1;
    for (int c = 0; c < 6; c++) begin
      #1 chk($sformatf("busy_hold%0d", c),
             {30'd0, out_valid, grant1}, 0);
      tick();
    end
    busy_in = 0;
    #1 chk("busy_idle", {31'd0, out_valid}, 0);
    tick();
    req1 = 0;
    #1 chk("busy_start", {30'd0, out_valid, grant1}, 3);
    for (int c = 0; c < 5; c++) tick();

    // Asynchronous reset in the middle of a frame
    req0 = 1; len0 = 8;
    tick();
    req0 = 0;
    for (int c = 0; c < 3; c++) tick();
    #1 chk("mid_bit3", {29'd0, out_valid, grant0, rd0}, 7);
    #1 reset = 1;
    #1 chk("async_rst", {28'd0, out_valid, grant0, rd0, frame_last}, 0);
    @(negedge clk);
    reset = 0;
    idx0 = 0; idx1 = 0;
    req0 = 1; req1 = 1; len0 = 2; len1 = 2;
    tick();
    req0 = 0; req1 = 0;
    #1 chk("post_rst_g0", {29'd0, out_valid, grant0, grant1}, 6);
    for (int c = 0; c < 5; c++) tick();

    // Clock-enable stall mid-frame
    pay1 = {{58{1'b1}}, 6'b101101};
    idx1 = 0;
    req1 = 1; len1 = 6;
    tick();
    req1 = 0;
    nb = 0; st = 0; lastpos = 0; rds = 0; dbits = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      enb = (nb == 2 && st < 3) ? 1'b0 : 1'b1;
      #1;
      if (!enb) begin
        st++;
        chk($sformatf("stall%0d", st),
            {29'd0, rd1, out_valid, out_data}, 3);
      end else if (out_valid) begin
        if (nb < 6) dbits[nb] = out_data;
        if (rd1) rds++;
        nb++;
        if (frame_last) lastpos = nb;
      end else if (nb > 0) begin
        done = 1;
      end
      tick();
    end
    enb = 1;
    chk("stall_bits", nb, 6);
    chk("stall_last", lastpos, 6);
    chk("stall_rds", rds, 6);
    chk("stall_data", {26'd0, dbits}, 32'b101101);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/polar_frame_scheduler.md
Name: polar_frame_scheduler

Overview:
- Two-requester frame scheduler ahead of the polar encoder framing stage.
- Arbitrates round-robin between two bit-serial payload sources and drives the framing stage's serial data/valid input with exactly len bits per frame.
- Inserts a guaranteed valid-low gap between frames so the downstream start/end edge detection sees every frame boundary.
- Holds off new frames while the encoder reports busy.

Parameters:
LEN_W, 10, width of frame-length inputs and internal bit counter
MAX_LEN, 1023, largest accepted frame length; must be <= 2^LEN_W-1
GAP_CYCLES, 1, enb-qualified cycles of out_valid low after every frame; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
enb  in  1  clock enable; all state advances only when enb=1
req0  in  1  source 0 has a frame pending
len0  in  LEN_W  source 0 frame length in bits
bit0  in  1  source 0 current payload bit
rd0  out  1  source 0 pop strobe; present next bit on the following cycle
req1  in  1  source 1 has a frame pending
len1  in  LEN_W  source 1 frame length in bits
bit1  in  1  source 1 current payload bit
rd1  out  1  source 1 pop strobe
busy_in  in  1  downstream encoder busy; blocks frame start
out_data  out  1  serial bit to framing stage (ufix1)
out_valid  out  1  serial valid to framing stage
grant0  out  1  source 0 owns the datapath (SEND state)
grant1  out  1  source 1 owns the datapath (SEND state)
frame_last  out  1  high with the last valid bit of a frame
err_len  out  1  one-cycle pulse: granted request had illegal length

Behaviour:
- States: IDLE, SEND, GAP. Registers: state, sel, rr_ptr, cnt[LEN_W], len_q[LEN_W], gap_cnt[4], err_len.
- Reset (async, immediate on all outputs): state=IDLE, rr_ptr=0 (source 0 preferred), cnt=0, gap_cnt=0, err_len=0. Every output is 0 during reset.
- IDLE, enb=1, busy_in=0, and at least one req:
  - Pick a winner. If only one req, that source wins. If both, the source != rr_ptr wins, except after reset, when source 0 wins.
  - Set rr_ptr=winner. Latch len_q and sel.
  - If the latched length is 0 or > MAX_LEN: pulse err_len for one cycle and stay in IDLE.
  - Otherwise go to SEND with cnt=0.
- busy_in is sampled only in IDLE. busy_in rising mid-frame does not interrupt the frame.
- SEND: out_valid=1, grant[sel]=1, out_data=bit[sel] (combinational mux from registered sel).
  - rd[sel] = enb.
  - On each enb cycle, cnt increments.
  - frame_last = (cnt == len_q-1).
  - When frame_last and enb: go to GAP with gap_cnt=0.
- Latency: accept edge → first out_valid on the next cycle. A frame of len L occupies exactly L enb cycles of out_valid.
- GAP: out_valid=0 and grants=0. gap_cnt increments per enb cycle; return to IDLE when gap_cnt == GAP_CYCLES-1.
- Minimum period per frame: 1 (IDLE) + L + GAP_CYCLES enb cycles.
- enb=0: state, cnt and gap_cnt are frozen. out_valid/grant/out_data hold their values; rd0/rd1 stay 0.
- Mid-frame changes:
  - req deassertion mid-frame is ignored; the frame runs to completion.
  - Changes to len0/len1 mid-frame are ignored (len_q is latched).
  - Bits presented by the source while not granted are ignored.
- When out_valid=0, out_data is forced to 0 (matches framing stage zeroing of invalid data).
- Back-to-back requests: with both reqs held high, grants alternate strictly 0,1,0,1…, always separated by the gap plus one IDLE cycle.
- Illegal length: the error consumes the source's turn (rr_ptr updates) but no data is popped. The source must drop or fix its req.

Test Plan:
- req0=1, len0=4, bits 1,0,1,1, busy_in=0 → out_valid high exactly 4 cycles starting 1 cycle after accept; out_data=1,0,1,1; rd0 4 pulses; frame_last on 4th bit; ≥1 cycle out_valid=0 after.
- req0=req1=1 held, len0=3, len1=5, GAP_CYCLES=1 → grant sequence 0,1,0,1; valid runs of 3,5,3,5; each run separated by exactly 2 low cycles (gap + IDLE).
- req0=1, len0=0, req1=1, len1=2 → err_len one pulse, no out_valid for source 0; next frame granted to source 1 with 2 valid bits.
- busy_in=1 with req1=1 for 6 cycles → no grant, out_valid=0; busy_in falls → grant1 and out_valid rise one cycle after the first IDLE cycle with busy_in=0.
- len0=8, reset asserted on bit 3 → out_valid, grant0, rd0 drop to 0 asynchronously; after release, simultaneous reqs → source 0 granted first.
- len1=6, enb=0 for 3 cycles after bit 2 → cnt frozen, rd1=0 during stall; total valid bits with enb=1 still 6, frame_last on 6th.
